fetch_credit_ctrl: RTL
======================

FETCH_CREDIT_CTRL -- requirements
Module: fetch_credit_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8: capacity in entries of the downstream compress FIFO.
REQ-002 SHALL have parameter FETCH_WIDTH, default 2: maximum entries delivered per fetch response.
REQ-003 SHALL have parameter MAX_INFLIGHT, default 4: maximum outstanding fetch requests.
REQ-004 clk  in  1  sole clock; all state updates on posedge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 redirect_i  in  1  backend PC redirect; kills all older fetch work.
REQ-007 fetch_req_valid_o  out  1 / fetch_req_ready_i  in  1  fetch request handshake; fires when both are high.
REQ-008 fetch_req_epoch_o  out  1  epoch tag sent with each request.
REQ-009 fetch_resp_valid_i  in  1 / fetch_resp_num_i  in  $clog2(FETCH_WIDTH+1) / fetch_resp_epoch_i  in  1  response; no backpressure.
REQ-010 fifo_write_valid_o  out  1 / fifo_write_num_o  out  $clog2(FETCH_WIDTH+1)  FIFO write command.
REQ-011 fifo_flush_o  out  1  FIFO flush.
REQ-012 fifo_pop_i  in  1 / fifo_pop_num_i  in  $clog2(FETCH_WIDTH+1)  entries consumed from the FIFO this cycle.
REQ-013 err_o  out  1  sticky accounting error.

Function
REQ-014 SHALL track occ (0..DEPTH), inflight (0..MAX_INFLIGHT) and epoch_q (1 bit).
REQ-015 SHALL define free = DEPTH - occ - inflight*FETCH_WIDTH, computed at width $clog2(DEPTH)+2 signed, so it never wraps.
REQ-016 SHALL drive fetch_req_valid_o = (state==RUN) & (free >= FETCH_WIDTH) & (inflight < MAX_INFLIGHT), from registered state only.
REQ-017 SHALL tie fetch_req_epoch_o to epoch_q; a request firing in the redirect cycle carries the old epoch.
REQ-018 Request fire SHALL increment inflight; every response SHALL decrement inflight, current or stale; both in one cycle leave it unchanged.
REQ-019 A response SHALL be current iff fetch_resp_epoch_i==epoch_q, redirect_i==0 and state==RUN.
REQ-020 For a current response, fifo_write_valid_o=1 and fifo_write_num_o=fetch_resp_num_i, combinationally in the same cycle, and occ SHALL add fetch_resp_num_i.
REQ-021 Stale responses SHALL be dropped: fifo_write_valid_o=0 and occ unchanged.
REQ-022 In RUN, fifo_pop_i SHALL subtract fifo_pop_num_i from occ; same-cycle write and pop SHALL net out.
REQ-023 An occ underflow (pop > occ) SHALL saturate occ at 0 and set err_o; an inflight underflow SHALL do the same.
REQ-024 Credit gating SHALL guarantee the FIFO never overflows; FIFO write_ready is therefore not consulted.
REQ-025 States: RUN, FLUSH, and DRAIN (DRAIN only per REQ-031). Transitions:
- RUN, on redirect_i: go to FLUSH, toggle epoch_q, clear occ.
- FLUSH: always leaves after one cycle (to RUN, or per REQ-031).
- DRAIN: returns to RUN when inflight==0.
REQ-026 fifo_flush_o SHALL be 1 exactly while in FLUSH; pops SHALL be ignored there and occ held at 0.
REQ-027 A redirect_i in FLUSH or DRAIN SHALL re-enter FLUSH and toggle epoch_q again.

Reset
REQ-028 Reset SHALL set state=RUN, occ=0, inflight=0, epoch_q=0 and err_o=0.
REQ-029 Output values during reset: fetch_req_valid_o=1 (DEPTH>=FETCH_WIDTH), fifo_write_valid_o=0, fifo_flush_o=0.
REQ-030 Reset mid-operation SHALL discard all counters; responses after reset are treated per epoch_q=0.

Configuration
REQ-031 Macro FETCH_CTRL_DRAIN_EN: when defined, FLUSH SHALL go to DRAIN if inflight!=0 (else RUN), and no request issues until all stale responses return; when undefined, the DRAIN state is absent, FLUSH always goes to RUN, and stale responses are filtered by epoch alone.

Structure
REQ-032 Shared package SHALL hold the state enum (RUN/FLUSH/DRAIN) and the epoch type, for reuse by the fetch unit.
REQ-033 SHALL be a single module with no sub-modules; the counters are inline.

Verification
REQ-034 Reset, never pop, respond with num=2 to each request: exactly 4 requests fire, then valid_o stays 0 with occ=8, free=0.
REQ-035 occ=8, pop 2: valid_o rises the next cycle; request fires; inflight=1, free=0.
REQ-036 inflight=2, redirect: fifo_flush_o=1 for one cycle; both old-epoch responses dropped; occ=0, inflight=0 afterwards.
REQ-037 Same cycle: request fire, current response num=1, and pop 1: inflight and occ unchanged, fifo_write_valid_o=1.
REQ-038 With FETCH_CTRL_DRAIN_EN, redirect with inflight=3: state FLUSH then DRAIN; valid_o=0 until the third response, RUN the next cycle.
REQ-039 Pop 2 with occ=1: occ=0, err_o=1 and held until rst.

Source files
------------

// File: rtl/fetch_credit_ctrl_pkg.sv
// Shared types for the fetch credit controller and the fetch unit that tags requests.
// The DRAIN state is only reachable when FETCH_CTRL_DRAIN_EN is defined.
package fetch_credit_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef logic epoch_t;

endpackage

// File: rtl/fetch_credit_ctrl.sv
// Credit-based fetch request gating in front of the compress FIFO, with epoch-based
// filtering of responses that predate a redirect. Optional macro: FETCH_CTRL_DRAIN_EN.
module fetch_credit_ctrl
  import fetch_credit_ctrl_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int FETCH_WIDTH  = 2,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               redirect_i,
  output logic                               fetch_req_valid_o,
  input  logic                               fetch_req_ready_i,
  output logic                               fetch_req_epoch_o,
  input  logic                               fetch_resp_valid_i,
  input  logic [$clog2(FETCH_WIDTH+1)-1:0]   fetch_resp_num_i,
  input  logic                               fetch_resp_epoch_i,
  output logic                               fifo_write_valid_o,
  output logic [$clog2(FETCH_WIDTH+1)-1:0]   fifo_write_num_o,
  output logic                               fifo_flush_o,
  input  logic                               fifo_pop_i,
  input  logic [$clog2(FETCH_WIDTH+1)-1:0]   fifo_pop_num_i,
  output logic                               err_o
);

  localparam int NUM_W  = $clog2(FETCH_WIDTH + 1);
  localparam int OCC_W  = $clog2(DEPTH + 1);
  localparam int OCC_X  = OCC_W + 2;
  localparam int INF_W  = $clog2(MAX_INFLIGHT + 1);
  localparam int FREE_W = $clog2(DEPTH) + 2;

  state_t                    state, state_nxt;
  epoch_t                    epoch_q, epoch_nxt;
  logic [OCC_W-1:0]          occ, occ_nxt;
  logic [INF_W-1:0]          inflight, inflight_nxt;
  logic                      err_q, err_nxt;
  logic                      occ_uf;
  logic signed [FREE_W-1:0]  free;
  logic                      fire;
  logic                      current;
  logic [NUM_W-1:0]          wr_num;
  logic [NUM_W-1:0]          pop_num;

  // Occupancy update that clamps at zero; the MSB of the result flags an underflow.
  function automatic logic [OCC_W:0] occ_sat(input logic [OCC_W-1:0] cur,
                                             input logic [NUM_W-1:0] add,
                                             input logic [NUM_W-1:0] sub);
    logic [OCC_X-1:0] sum;
    sum = OCC_X'(cur) + OCC_X'(add);
    if (sum < OCC_X'(sub)) occ_sat = {1'b1, {OCC_W{1'b0}}};
    else                   occ_sat = {1'b0, OCC_W'(sum - OCC_X'(sub))};
  endfunction

  // Signed credit so that over-committed states read as negative instead of wrapping.
  assign free = FREE_W'(DEPTH) - FREE_W'(occ) - FREE_W'(32'(inflight) * FETCH_WIDTH);

  assign fetch_req_valid_o = (state == RUN) &&
                             (free >= $signed(FREE_W'(FETCH_WIDTH))) &&
                             (32'(inflight) < MAX_INFLIGHT);
  assign fetch_req_epoch_o = epoch_q;
  assign fire              = fetch_req_valid_o && fetch_req_ready_i;

  assign current = fetch_resp_valid_i && (fetch_resp_epoch_i == epoch_q) &&
                   !redirect_i && (state == RUN);
  assign wr_num  = current ? fetch_resp_num_i : '0;
  assign pop_num = fifo_pop_i ? fifo_pop_num_i : '0;

  assign fifo_write_valid_o = current;
  assign fifo_write_num_o   = wr_num;
  assign fifo_flush_o       = (state == FLUSH);
  assign err_o              = err_q;

  always_comb begin
    state_nxt    = state;
    epoch_nxt    = epoch_q;
    occ_nxt      = occ;
    inflight_nxt = inflight;
    err_nxt      = err_q;
    occ_uf       = 1'b0;

    // Every response retires one request, stale or not.
    if (fire && !fetch_resp_valid_i) begin
      inflight_nxt = inflight + INF_W'(1);
    end else if (!fire && fetch_resp_valid_i) begin
      if (inflight == '0) err_nxt = 1'b1;
      else                inflight_nxt = inflight - INF_W'(1);
    end

    if (state == RUN) begin
      if (redirect_i) begin
        occ_nxt = '0;
      end else begin
        {occ_uf, occ_nxt} = occ_sat(occ, wr_num, pop_num);
        if (occ_uf) err_nxt = 1'b1;
      end
    end else begin
      occ_nxt = '0;
    end

    if (redirect_i) begin
      state_nxt = FLUSH;
      epoch_nxt = ~epoch_q;
    end else begin
      case (state)
        RUN:   state_nxt = RUN;
`ifdef FETCH_CTRL_DRAIN_EN
        FLUSH: state_nxt = (inflight_nxt != '0) ? DRAIN : RUN;
        DRAIN: state_nxt = (inflight_nxt == '0) ? RUN : DRAIN;
`else
        FLUSH: state_nxt = RUN;
`endif
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      epoch_q  <= 1'b0;
      occ      <= '0;
      inflight <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      epoch_q  <= epoch_nxt;
      occ      <= occ_nxt;
      inflight <= inflight_nxt;
      err_q    <= err_nxt;
    end
  end

endmodule
